// File: rtl/stopwatch_disp_pkg.sv
// Shared definitions for the stopwatch display driver: FSM state encoding,
// scan-slot digit indices and active-low 7-segment patterns {g,f,e,d,c,b,a}.
package stopwatch_disp_pkg;

  typedef enum logic {
    ST_LIVE     = 1'b0,
    ST_LAP_HOLD = 1'b1
  } disp_state_e;

  // Scan slot -> displayed digit (slot 0 is the rightmost anode)
  localparam logic [1:0] DIG_MS      = 2'd0;
  localparam logic [1:0] DIG_SEC_LSD = 2'd1;
  localparam logic [1:0] DIG_SEC_MSD = 2'd2;
  localparam logic [1:0] DIG_MIN     = 2'd3;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low segment patterns
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Decimal points separate M.SS.m, so they sit on the seconds-lsd and minutes slots
  function automatic logic dp_lit(input logic [1:0] idx);
    return (idx == DIG_SEC_LSD) || (idx == DIG_MIN);
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_7seg
  import stopwatch_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_driver.sv
// Multiplexed 4-digit display driver for the stopwatch: scans live or held lap
// digits, holds a lap capture for a fixed time, and blinks the whole display
// while a flash request is active. All display outputs are registered.
module stopwatch_display_driver
  import stopwatch_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_CYCLES = 300000000,
  parameter int FLASH_HALF  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes,
  input  logic [3:0] seconds_msd,
  input  logic [3:0] seconds_lsd,
  input  logic [3:0] ms_msd,
  input  logic [3:0] lap_ct_ms,
  input  logic [3:0] lap_ctsecondslsd,
  input  logic [3:0] lap_ct_secondsmsd,
  input  logic [3:0] lap_ctminutes,
  input  logic       run_catch,
  input  logic       start_catch,
  input  logic       lap_press,
  input  logic       flash,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  logic [REF_W-1:0]   refresh_cnt_reg;
  logic [1:0]         scan_idx_reg;
  disp_state_e        state_reg, state_next;
  logic [HOLD_W-1:0]  hold_cnt_reg, hold_cnt_next;
  logic [FLASH_W-1:0] flash_cnt_reg;
  logic               flash_blank_reg;
  logic [3:0]         an_reg, an_next, an_scan;
  logic [6:0]         seg_reg, seg_next, seg_dec;
  logic               dp_reg, dp_next;
  logic [3:0]         live_dig [4];
  logic [3:0]         lap_dig  [4];
  logic [3:0]         digit_sel;
  logic               blank_now;

  // The running level never changes what is shown; a lap hold still times out while stopped
  logic unused_run;
  assign unused_run = run_catch;

  assign live_dig[DIG_MS]      = ms_msd;
  assign live_dig[DIG_SEC_LSD] = seconds_lsd;
  assign live_dig[DIG_SEC_MSD] = seconds_msd;
  assign live_dig[DIG_MIN]     = minutes;
  assign lap_dig[DIG_MS]       = lap_ct_ms;
  assign lap_dig[DIG_SEC_LSD]  = lap_ctsecondslsd;
  assign lap_dig[DIG_SEC_MSD]  = lap_ct_secondsmsd;
  assign lap_dig[DIG_MIN]      = lap_ctminutes;

  assign digit_sel = (state_reg == ST_LAP_HOLD) ? lap_dig[scan_idx_reg] : live_dig[scan_idx_reg];

  // One anode per slot, driven low when the scan index points at it
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_anode
    assign an_scan[gi] = (scan_idx_reg != 2'(gi));
  end

  bcd_to_7seg u_dec (
    .bcd (digit_sel),
    .seg (seg_dec)
  );

  // Blanking follows the flash level directly so dropping flash restores the display at once
  assign blank_now = flash & flash_blank_reg;

  // Scan timing: advance to the next digit slot every REFRESH_DIV cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_reg <= '0;
      scan_idx_reg    <= DIG_MS;
    end else if (refresh_cnt_reg == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt_reg <= '0;
      scan_idx_reg    <= scan_idx_reg + 2'd1;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end
  end

  // Display-source state and lap hold timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_LIVE;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Start overrides everything; a lap press (re)arms the hold; the hold runs down to LIVE
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    if (start_catch) begin
      state_next    = ST_LIVE;
      hold_cnt_next = '0;
    end else if (lap_press) begin
      state_next    = ST_LAP_HOLD;
      hold_cnt_next = HOLD_W'(HOLD_CYCLES - 1);
    end else if (state_reg == ST_LAP_HOLD) begin
      if (hold_cnt_reg == '0) begin
        state_next = ST_LIVE;
      end else begin
        hold_cnt_next = hold_cnt_reg - 1'b1;
      end
    end
  end

  // Blink phase: toggles every FLASH_HALF cycles while flash is requested, starts visible
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flash_cnt_reg   <= '0;
      flash_blank_reg <= 1'b0;
    end else if (!flash) begin
      flash_cnt_reg   <= '0;
      flash_blank_reg <= 1'b0;
    end else if (flash_cnt_reg == FLASH_W'(FLASH_HALF - 1)) begin
      flash_cnt_reg   <= '0;
      flash_blank_reg <= ~flash_blank_reg;
    end else begin
      flash_cnt_reg <= flash_cnt_reg + 1'b1;
    end
  end

  // Next display value: current slot's digit, or everything dark in the blank phase
  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_BLANK;
    dp_next  = 1'b1;
    if (!blank_now) begin
      an_next  = an_scan;
      seg_next = seg_dec;
      dp_next  = ~dp_lit(scan_idx_reg);
    end
  end

  // Output register: an, seg and dp always change together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_reg  <= AN_OFF;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Bench for stopwatch_display_driver: directed scenarios plus random traffic,
// every cycle compared against a timeline model built from cycle arithmetic.
module tb_stopwatch_display_driver;

  localparam int R = 4;
  localparam int H = 20;
  localparam int F = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] minutes = '0, seconds_msd = '0, seconds_lsd = '0, ms_msd = '0;
  logic [3:0] lap_ct_ms = '0, lap_ctsecondslsd = '0, lap_ct_secondsmsd = '0, lap_ctminutes = '0;
  logic       run_catch = 1'b0, start_catch = 1'b0, lap_press = 1'b0, flash = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  // Model state: edges since reset release, last edge that shows lap digits,
  // and how many consecutive edges flash has been high.
  int m_t        = 0;
  int m_lap_last = -1;
  int m_run      = 0;

  // Segments lit per decimal digit, by name
  string lit_tbl [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  stopwatch_display_driver #(
    .REFRESH_DIV (R),
    .HOLD_CYCLES (H),
    .FLASH_HALF  (F)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .minutes           (minutes),
    .seconds_msd       (seconds_msd),
    .seconds_lsd       (seconds_lsd),
    .ms_msd            (ms_msd),
    .lap_ct_ms         (lap_ct_ms),
    .lap_ctsecondslsd  (lap_ctsecondslsd),
    .lap_ct_secondsmsd (lap_ct_secondsmsd),
    .lap_ctminutes     (lap_ctminutes),
    .run_catch         (run_catch),
    .start_catch       (start_catch),
    .lap_press         (lap_press),
    .flash             (flash),
    .an                (an),
    .seg               (seg),
    .dp                (dp)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_t);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    string      s;
    logic [6:0] lit;
    lit = '0;
    s = (d <= 4'd9) ? lit_tbl[d] : "g";
    for (int i = 0; i < s.len(); i++) lit[int'(s[i]) - 97] = 1'b1;
    return ~lit;
  endfunction

  function automatic logic [3:0] pick(input int idx, input bit lap);
    case (idx)
      0:       return lap ? lap_ct_ms         : ms_msd;
      1:       return lap ? lap_ctsecondslsd  : seconds_lsd;
      2:       return lap ? lap_ct_secondsmsd : seconds_msd;
      default: return lap ? lap_ctminutes     : minutes;
    endcase
  endfunction

  task automatic model_reset();
    m_t        = 0;
    m_lap_last = -1;
    m_run      = 0;
  endtask

  // One clock: predict outputs from the inputs present at the edge, then compare
  task automatic step();
    int         idx;
    bit         blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge clk);
    idx   = (m_t / R) % 4;
    blank = flash && (((m_run / F) % 2) == 1);
    if (blank) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << idx);
      e_seg = seg_of(pick(idx, m_t <= m_lap_last));
      e_dp  = !(idx == 1 || idx == 3);
    end
    if (start_catch)    m_lap_last = m_t;
    else if (lap_press) m_lap_last = m_t + H;
    m_run = flash ? m_run + 1 : 0;
    m_t++;
    #1;
    check_val("an", 32'(an), 32'(e_an));
    check_val("seg", 32'(seg), 32'(e_seg));
    check_val("dp", 32'(dp), 32'(e_dp));
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_lap();
    lap_press = 1'b1; step(); lap_press = 1'b0;
  endtask

  // Reset dropped between edges must darken the display with no clock edge
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    check_val("rst_an", 32'(an), 32'hF);
    check_val("rst_seg", 32'(seg), 32'h7F);
    check_val("rst_dp", 32'(dp), 32'h1);
    @(posedge clk); #1;
    check_val("rst_hold_an", 32'(an), 32'hF);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic set_live(input logic [3:0] m, input logic [3:0] sm, input logic [3:0] sl, input logic [3:0] ms);
    minutes = m; seconds_msd = sm; seconds_lsd = sl; ms_msd = ms;
  endtask

  initial begin
    // Power-up reset
    repeat (2) @(posedge clk);
    #1;
    check_val("init_an", 32'(an), 32'hF);
    check_val("init_seg", 32'(seg), 32'h7F);
    check_val("init_dp", 32'(dp), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Live 9:59.9
    set_live(4'd9, 4'd5, 4'd9, 4'd9);
    steps(32);
    $display("txn live_9599 checks=%0d", checks);

    // Lap hold of 5:06.7 over live 1:23.4
    set_live(4'd1, 4'd2, 4'd3, 4'd4);
    lap_ctminutes = 4'd5; lap_ct_secondsmsd = 4'd0; lap_ctsecondslsd = 4'd6; lap_ct_ms = 4'd7;
    pulse_lap();
    steps(30);
    $display("txn lap_hold checks=%0d", checks);

    // Re-press during hold, then start and lap together
    pulse_lap();
    steps(14);
    pulse_lap();
    steps(26);
    start_catch = 1'b1; lap_press = 1'b1; step();
    start_catch = 1'b0; lap_press = 1'b0;
    steps(10);
    $display("txn lap_extend_start checks=%0d", checks);

    // Flash for 32 cycles, then release
    flash = 1'b1;
    steps(32);
    flash = 1'b0;
    steps(8);
    $display("txn flash checks=%0d", checks);

    // Non-decimal digit shows a dash
    seconds_msd = 4'hC;
    steps(16);
    $display("txn dash checks=%0d", checks);

    // Reset during lap hold and blank phase
    pulse_lap();
    flash = 1'b1;
    steps(12);
    async_reset();
    flash = 1'b0;
    steps(20);
    $display("txn reset_mid_hold checks=%0d", checks);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        set_live(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        lap_ct_ms = 4'($urandom_range(0, 15)); lap_ctsecondslsd = 4'($urandom_range(0, 15));
        lap_ct_secondsmsd = 4'($urandom_range(0, 15)); lap_ctminutes = 4'($urandom_range(0, 15));
      end
      lap_press   = ($urandom_range(0, 11) == 0);
      start_catch = ($urandom_range(0, 29) == 0);
      run_catch   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) flash = ~flash;
      if ($urandom_range(0, 299) == 0) async_reset();
      step();
      if ((i % 250) == 249) $display("txn random_%0d checks=%0d", i / 250, checks);
    end
    lap_press = 1'b0; start_catch = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_driver.md
STOPWATCH_DISPLAY_DRIVER -- requirements
Module: stopwatch_display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit scan slot (1 ms at 100 MHz).
REQ-002 SHALL have parameter HOLD_CYCLES, default 300000000, lap-hold display duration in clk cycles (3 s).
REQ-003 SHALL have parameter FLASH_HALF, default 25000000, clk cycles per flash half-period (2 Hz blink).
REQ-004 SHALL have port clk, input, 1, system clock (100 MHz); single clock domain.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port minutes, seconds_msd, seconds_lsd, ms_msd, input, 4 each, live BCD digits.
REQ-007 SHALL have port lap_ct_ms, lap_ctsecondslsd, lap_ct_secondsmsd, lap_ctminutes, input, 4 each, captured lap BCD digits.
REQ-008 SHALL have port run_catch, input, 1, stopwatch running level.
REQ-009 SHALL have port start_catch, input, 1, one-cycle start pulse.
REQ-010 SHALL have port lap_press, input, 1, one-cycle lap pulse.
REQ-011 SHALL have port flash, input, 1, countdown-expired blink request level.
REQ-012 SHALL have port an, output, 4, active-low digit anodes; an[0] rightmost.
REQ-013 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-014 SHALL have port dp, output, 1, active-low decimal point.

Function
REQ-015 Scan: refresh counter counts 0..REFRESH_DIV-1; at terminal count, scan index (2 bits) increments and wraps 3->0.
REQ-016 Digit map: index 0 = ms digit, 1 = seconds_lsd, 2 = seconds_msd, 3 = minutes; an drives a single low bit at position = index.
REQ-017 Source: LIVE state selects live digits; LAP_HOLD state selects lap digits.
REQ-018 an, seg and dp SHALL be registered and update on the same edge; input digit change reaches seg 1 clk later.
REQ-019 Decode: BCD 0-9 to standard 7-seg patterns; values 10-15 show a single dash (g only, seg = 7'b0111111).
REQ-020 dp low on index 1 and 3 (M.SS.m format), high otherwise.
REQ-021 FSM states: LIVE, LAP_HOLD. LIVE->LAP_HOLD on lap_press; hold counter loads HOLD_CYCLES-1.
REQ-022 In LAP_HOLD, the hold counter decrements each clk; at 0 go to LIVE.
REQ-023 lap_press in LAP_HOLD reloads the hold counter and stays in LAP_HOLD.
REQ-024 start_catch in either state forces LIVE; start_catch wins over a simultaneous lap_press.
REQ-025 run_catch low does not alter FSM; lap hold expires normally while stopped.
REQ-026 Flash: while flash high, flash counter counts 0..FLASH_HALF-1 and toggles the phase at terminal count; phase starts visible.
REQ-027 In blank phase an = 4'b1111, seg = all ones, dp = 1; scan continues internally.
REQ-028 flash low clears the flash counter and phase to visible within 1 clk.
REQ-029 Flash applies in both FSM states.

Reset
REQ-030 rst low SHALL immediately (asynchronously) force an = 4'b1111, seg = 7'b1111111, dp = 1, state LIVE, scan index 0, all counters 0, flash phase visible.
REQ-031 Reset asserted mid-hold or mid-blink SHALL abandon the operation; after release display resumes in LIVE at index 0.
REQ-032 First anode drives an[0] low on the first clk edge after rst release.

Structure
REQ-033 Shared package stopwatch_disp_pkg SHALL hold FSM state encodings, digit-index constants, 7-seg pattern constants (0-9, dash, blank).
REQ-034 BCD decode SHALL be a sub-module bcd_to_7seg (4-bit in, 7-bit active-low out, combinational); all other logic stays in the top.

Verification (REFRESH_DIV=4, HOLD_CYCLES=20, FLASH_HALF=8)
REQ-035 Live 9:59.9, no flash -> an cycles 1110,1101,1011,0111 every 4 clk; seg 0010000 on each digit; dp low on an 1101 and 0111.
REQ-036 Live 1:23.4, lap digits 5:06.7, lap_press pulse -> lap digits shown for exactly 20 clk, then live digits.
REQ-037 lap_press again at clk 15 of hold -> hold extends to 20 clk after second pulse; start_catch and lap_press same cycle -> live digits, no hold.
REQ-038 flash high 32 clk -> an 1111 during clk 8-15 and 24-31, visible otherwise; flash low -> visible next clk.
REQ-039 seconds_msd = 4'hC -> dash (0111111) on index 2 only.
REQ-040 rst low during lap hold and blank phase -> an=1111, seg=1111111, dp=1 without a clk edge; on release LIVE at index 0.
